// File: rtl/mul24_if.sv
// Operand/product handshake bundle for the sequential 24x24 multiplier.
// The master side presents operands and consumes products; the slave side is the multiplier.
interface mul24_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a;
  logic [23:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] c;
  logic        busy;

  modport master (
    output in_valid, a, b, flush, out_ready,
    input  in_ready, out_valid, c, busy
  );

  modport slave (
    input  in_valid, a, b, flush, out_ready,
    output in_ready, out_valid, c, busy
  );
endinterface

// File: rtl/mul24_seq_ctrl.sv
// Sequential 24x24 unsigned multiplier: one shared 8x8 array multiplier walks the
// nine byte pairs and accumulates the shifted partial products into a 48-bit register.
module mul24_seq_ctrl #(
  parameter bit ZERO_SKIP = 1'b1
) (
  input logic    clk,
  input logic    rst_n,
  mul24_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [23:0] a_r;
  logic [23:0] b_r;
  logic [47:0] acc_r;
  logic [3:0]  k_r;

  logic        accept_s;
  logic        zero_s;
  logic [1:0]  i_s;
  logic [1:0]  j_s;
  logic [7:0]  a_byte_s;
  logic [7:0]  b_byte_s;
  logic [15:0] prod_s;
  logic [5:0]  shift_s;
  logic [47:0] term_s;

  // flush wins over a simultaneous accept
  assign accept_s = bus.in_valid & (state_r == IDLE) & ~bus.flush;
  assign zero_s   = ZERO_SKIP & ((bus.a == 24'd0) | (bus.b == 24'd0));

  // Step counter k maps to byte pair (i, j) = (k/3, k%3)
  always_comb begin
    i_s = 2'd0;
    j_s = 2'd0;
    case (k_r)
      4'd0:    begin i_s = 2'd0; j_s = 2'd0; end
      4'd1:    begin i_s = 2'd0; j_s = 2'd1; end
      4'd2:    begin i_s = 2'd0; j_s = 2'd2; end
      4'd3:    begin i_s = 2'd1; j_s = 2'd0; end
      4'd4:    begin i_s = 2'd1; j_s = 2'd1; end
      4'd5:    begin i_s = 2'd1; j_s = 2'd2; end
      4'd6:    begin i_s = 2'd2; j_s = 2'd0; end
      4'd7:    begin i_s = 2'd2; j_s = 2'd1; end
      4'd8:    begin i_s = 2'd2; j_s = 2'd2; end
      default: begin i_s = 2'd0; j_s = 2'd0; end
    endcase
  end

  // Operand byte selection feeding the shared 8x8 multiplier
  always_comb begin
    a_byte_s = 8'd0;
    b_byte_s = 8'd0;
    case (i_s)
      2'd0:    a_byte_s = a_r[7:0];
      2'd1:    a_byte_s = a_r[15:8];
      2'd2:    a_byte_s = a_r[23:16];
      default: a_byte_s = 8'd0;
    endcase
    case (j_s)
      2'd0:    b_byte_s = b_r[7:0];
      2'd1:    b_byte_s = b_r[15:8];
      2'd2:    b_byte_s = b_r[23:16];
      default: b_byte_s = 8'd0;
    endcase
  end

  assign prod_s  = {8'd0, a_byte_s} * {8'd0, b_byte_s};
  assign shift_s = {({1'b0, i_s} + {1'b0, j_s}), 3'b000};
  assign term_s  = {32'd0, prod_s} << shift_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    if (bus.flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s = zero_s ? DONE : CALC;
          end else begin
            state_s = IDLE;
          end
        end
        CALC: begin
          if (k_r == 4'd8) begin
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    bus.in_ready  = (state_r == IDLE);
    bus.out_valid = (state_r == DONE);
    bus.busy      = (state_r != IDLE);
  end

  assign bus.c = acc_r;

  // Operand capture and partial-product accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= 24'd0;
      b_r   <= 24'd0;
      acc_r <= 48'd0;
      k_r   <= 4'd0;
    end else if (bus.flush) begin
      acc_r <= 48'd0;
      k_r   <= 4'd0;
    end else if (accept_s) begin
      a_r   <= bus.a;
      b_r   <= bus.b;
      acc_r <= 48'd0;
      k_r   <= 4'd0;
    end else if (state_r == CALC) begin
      acc_r <= acc_r + term_s;
      k_r   <= k_r + 4'd1;
    end else begin
      acc_r <= acc_r;
      k_r   <= k_r;
    end
  end

endmodule

// File: doc/mul24_seq_ctrl.md
MUL24_SEQ_CTRL -- requirements
Module: mul24_seq_ctrl

Interface
REQ-001 Parameter ZERO_SKIP, default 1: when 1, a zero operand bypasses the iterative sequence.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  requester presents operands.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  24  unsigned multiplicand (mantissa incl. hidden bit).
REQ-007 b  input  24  unsigned multiplier.
REQ-008 flush  input  1  synchronous abort of any operation in progress.
REQ-009 out_valid  output  1  product c is valid.
REQ-010 out_ready  input  1  consumer accepts product.
REQ-011 c  output  48  unsigned product a*b.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL compute a*b using exactly one 8x8 unsigned array multiplier (16-bit product), time-shared over byte pairs.
REQ-014 The states SHALL be IDLE, CALC and DONE.
REQ-015 in_ready SHALL equal (state==IDLE); operands are accepted only on a cycle with in_valid & in_ready, and a, b are registered at that edge.
REQ-016 On accept, the block SHALL clear the 48-bit accumulator and the step counter k, then go to CALC; with ZERO_SKIP=1 and a==0 or b==0, it SHALL go directly to DONE with accumulator 0.
REQ-017 In CALC, step k (0..8) SHALL use i=k/3 and j=k%3, select a_reg[8i+7:8i] and b_reg[8j+7:8j], and add the 16-bit product shifted left by 8*(i+j) into the accumulator.
REQ-018 After the step k==8 add, the block SHALL go to DONE. A nonzero operation takes exactly 9 CALC cycles, and out_valid is first high 9 cycles after the accept edge.
REQ-019 With ZERO_SKIP=1 and a zero operand, out_valid SHALL be high 1 cycle after the accept edge.
REQ-020 Accumulator additions SHALL be 48-bit modulo; no carry-out is needed because (2^24-1)^2 < 2^48.
REQ-021 out_valid SHALL equal (state==DONE); c SHALL equal the accumulator and stay stable while out_valid & !out_ready.
REQ-022 In DONE, out_valid & out_ready SHALL return the state to IDLE; the next accept is possible one cycle later, with no back-to-back acceptance.
REQ-023 flush SHALL force IDLE at the next edge from any state, discarding the accumulator contents; flush takes priority over accept and over the out handshake in the same cycle.
REQ-024 In IDLE, in_valid & in_ready together with flush SHALL not accept the operands.
REQ-025 Changes on a/b while not in IDLE SHALL not affect the result in progress.
REQ-026 While in IDLE, c SHALL hold its last value; consumers qualify c with out_valid only.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, k=0, accumulator=0 and operand registers=0.
REQ-028 During and after reset, outputs SHALL be in_ready=1, out_valid=0, busy=0, c=48'h0.
REQ-029 Reset asserted mid-CALC or in DONE SHALL abandon the operation; after release, no out_valid is produced for it.

Verification
REQ-030 Scenario: a=24'hFFFFFF, b=24'hFFFFFF, out_ready=1 -> out_valid 9 cycles after accept, c=48'hFFFFFE000001, busy high throughout.
REQ-031 Scenario: a=24'h000003, b=24'h000005 -> c=48'h00000000000F after 9 cycles; a=24'h800000, b=24'h800000 -> c=48'h400000000000.
REQ-032 Scenario: ZERO_SKIP=1, a=0, b=24'h123456 -> out_valid 1 cycle after accept, c=0; with ZERO_SKIP=0 -> out_valid after 9 cycles, c=0.
REQ-033 Scenario: out_ready held low 5 cycles in DONE -> c and out_valid stable, in_ready=0, new in_valid ignored; on out_ready=1 -> IDLE next cycle.
REQ-034 Scenario: flush at CALC step k=4 -> IDLE next edge, out_valid never asserted; next operation a=24'h000002, b=24'h000007 -> c=48'hE.
REQ-035 Scenario: rst_n pulsed low mid-CALC -> out_valid=0, c=0, in_ready=1 during reset and after release; a following operation completes correctly.
